blink_period_meter: RTL and testbench

Measures the period of a slow external square wave (a blinking LED drive, a key or a sensor line) and reports it in prescaled time ticks. It is the receiving end of the team's divided-clock blink generators: those produce a fixed-period toggle from `CLOCK_50`, and this block recovers the period from such a signal for display or self-check. It sits between an asynchronous board input and a hex/LED display path.

---
 rtl/blink_period_meter_pkg.sv | 26 ++
 rtl/tick_prescaler.sv | 30 +++
 rtl/blink_period_meter.sv | 120 ++++++++++++
 tb/tb_blink_period_meter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/blink_period_meter_pkg.sv
// Shared types and helpers for the blink period meter.
package blink_period_meter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OVF  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        OVF  = ST_OVF
    } state_t;

    // Number of bits needed to hold the given value (at least 1).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned bits;
        bits = 1;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((value >> i) != 32'd0) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Mod-TICK_DIV counter; tick marks the last count, clr restarts the count.
module tick_prescaler
    import blink_period_meter_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic aclr,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   PW   = clogb2(TICK_DIV - 1);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count;

    always_ff @(posedge clk) begin
        if (!aclr) begin
            count <= '0;
        end else if (clr || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + PW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/blink_period_meter.sv
// Measures the period of a slow asynchronous square wave in prescaled ticks,
// rising edge to rising edge, with a sticky saturation flag.
module blink_period_meter
    import blink_period_meter_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned W        = 16
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic         sig_in,
    output logic [W-1:0] meas,
    output logic         meas_valid,
    output logic         overflow,
    output logic         armed
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic         s1;
    logic         s2;
    logic         s3;
    logic         rise_c;
    logic         tick;
    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic [W-1:0] meas_nxt;
    logic         meas_valid_nxt;
    logic         overflow_nxt;
    logic         armed_nxt;

    // Two-stage synchronizer plus previous-value stage for edge detection.
    always_ff @(posedge clk) begin
        if (!aclr) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_c = s2 & ~s3;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk  (clk),
        .aclr (aclr),
        .clr  (rise_c),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!aclr) begin
            state      <= IDLE;
            cnt        <= '0;
            meas       <= '0;
            meas_valid <= 1'b0;
            overflow   <= 1'b0;
            armed      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            meas       <= meas_nxt;
            meas_valid <= meas_valid_nxt;
            overflow   <= overflow_nxt;
            armed      <= armed_nxt;
        end
    end

    // A rise takes priority over a coincident saturating tick; the captured
    // result then saturates at CNT_MAX.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        meas_nxt       = meas;
        meas_valid_nxt = 1'b0;
        overflow_nxt   = overflow;
        armed_nxt      = armed;
        unique case (state)
            IDLE: begin
                if (rise_c) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    armed_nxt = 1'b1;
                end
            end
            RUN: begin
                if (rise_c) begin
                    meas_nxt       = (tick && (cnt != CNT_MAX)) ? cnt + W'(1) : cnt;
                    meas_valid_nxt = 1'b1;
                    cnt_nxt        = '0;
                end else if (tick) begin
                    if (cnt == CNT_MAX) begin
                        state_nxt    = OVF;
                        overflow_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + W'(1);
                    end
                end
            end
            OVF: begin
                if (rise_c) begin
                    state_nxt    = RUN;
                    cnt_nxt      = '0;
                    overflow_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_blink_period_meter.sv
// Directed bench for blink_period_meter with an event-level reference model.
module tb_blink_period_meter;

    localparam int TD   = 4;
    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int PH   = 4;

    logic         clk = 1'b0;
    logic         aclr;
    logic         sig_in;
    logic [W-1:0] meas;
    logic         meas_valid;
    logic         overflow;
    logic         armed;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: edge index, pending events, expected outputs.
    int n       = 0;
    int start_n = 0;
    int evq[$];
    int seen[$];
    bit m_prev  = 1'b0;
    bit m_armed = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_valid = 1'b0;
    int m_meas  = 0;
    bit ev;
    int q;

    always #5 clk = ~clk;

    blink_period_meter #(
        .TICK_DIV (TD),
        .W        (W)
    ) dut (
        .clk        (clk),
        .aclr       (aclr),
        .sig_in     (sig_in),
        .meas       (meas),
        .meas_valid (meas_valid),
        .overflow   (overflow),
        .armed      (armed)
    );

    task automatic chk(input string name, input logic [31:0] act, input int req);
        vectors++;
        if (act !== 32'(req)) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int seen_at(input int k);
        return (seen.size() > k) ? seen[k] : -1;
    endfunction

    // A rising edge sampled at edge e is acted on at edge e+2; a period is the
    // edge distance between accepted rises, floored to whole ticks.
    always @(posedge clk) begin
        n = n + 1;
        m_valid = 1'b0;
        if (!aclr) begin
            m_prev  = 1'b0;
            evq.delete();
            m_armed = 1'b0;
            m_ovf   = 1'b0;
            m_meas  = 0;
        end else begin
            ev = (evq.size() > 0) && (evq[0] == n);
            if (ev) void'(evq.pop_front());
            if (sig_in && !m_prev) evq.push_back(n + 2);
            m_prev = sig_in;
            if (ev) begin
                if (!m_armed) begin
                    m_armed = 1'b1;
                end else if (m_ovf) begin
                    m_ovf = 1'b0;
                end else begin
                    q       = (n - start_n) / TD;
                    m_meas  = (q > MAXV) ? MAXV : q;
                    m_valid = 1'b1;
                end
                start_n = n;
            end else if (m_armed && !m_ovf && ((n - start_n) == (MAXV + 1) * TD)) begin
                m_ovf = 1'b1;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("meas",       32'(meas),       m_meas);
            chk("meas_valid", 32'(meas_valid), int'(m_valid));
            chk("overflow",   32'(overflow),   int'(m_ovf));
            chk("armed",      32'(armed),      int'(m_armed));
            if (meas_valid === 1'b1) seen.push_back(int'(meas));
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #3;
    endtask

    task automatic period(input int p);
        sig_in = 1'b1;
        cyc(p / 2);
        sig_in = 1'b0;
        cyc(p - p / 2);
    endtask

    initial begin
        aclr   = 1'b0;
        sig_in = 1'b0;
        cyc(3);
        aclr = 1'b1;
        cyc(2);
        chk("reset_meas",  32'(meas),  0);
        chk("reset_armed", 32'(armed), 0);

        // 40-cycle square wave: first edge only arms.
        period(40);
        chk("first_edge_armed", 32'(armed), 1);
        chk("first_edge_novalid", 32'(seen.size()), 0);
        repeat (4) period(40);
        chk("p40_count", 32'(seen.size()), 4);
        chk("p40_last",  32'(seen_at(3)), 10);
        seen.delete();

        // Flooring and tick/rise coincidence.
        period(41);
        period(43);
        period(44);
        period(40);
        chk("p41_43_44_count", 32'(seen.size()), 4);
        chk("p41_val", 32'(seen_at(1)), 10);
        chk("p43_val", 32'(seen_at(2)), 10);
        chk("p44_val", 32'(seen_at(3)), 11);
        seen.delete();

        // 80-cycle period saturates; meas holds its old value.
        sig_in = 1'b1;
        cyc(40);
        sig_in = 1'b0;
        cyc(30);
        chk("ovf_set",  32'(overflow), 1);
        chk("ovf_meas", 32'(meas), 10);
        cyc(10);
        period(40);
        chk("ovf_cleared", 32'(overflow), 0);
        period(40);
        chk("post_ovf_count", 32'(seen.size()), 2);
        chk("post_ovf_val",   32'(seen_at(1)), 10);

        // Reset in the middle of a measurement.
        sig_in = 1'b1;
        cyc(20);
        sig_in = 1'b0;
        cyc(10);
        aclr = 1'b0;
        cyc(1);
        aclr = 1'b1;
        chk("mid_reset_meas",  32'(meas),  0);
        chk("mid_reset_armed", 32'(armed), 0);
        chk("mid_reset_ovf",   32'(overflow), 0);
        cyc(10);
        seen.delete();
        period(40);
        chk("rearm_armed",   32'(armed), 1);
        chk("rearm_novalid", 32'(seen.size()), 0);
        period(40);
        chk("rearm_count", 32'(seen.size()), 1);
        chk("rearm_val",   32'(seen_at(0)), 10);
        seen.delete();

        // One-cycle pulses every 12 cycles at an off-edge phase.
        for (int i = 0; i < 6; i++) begin
            #(PH);
            sig_in = 1'b1;
            #10;
            sig_in = 1'b0;
            #(110 - PH);
        end
        chk("pulse_count", 32'(seen.size()), 6);
        chk("pulse_first", 32'(seen_at(0)), 10);
        chk("pulse_val1",  32'(seen_at(1)), 3);
        chk("pulse_val5",  32'(seen_at(5)), 3);
        seen.delete();

        // Constant input: no results, saturation after 64 cycles of RUN.
        cyc(200);
        chk("const_low_novalid", 32'(seen.size()), 0);
        chk("const_low_ovf",     32'(overflow), 1);
        sig_in = 1'b1;
        cyc(5);
        chk("const_rise_clr", 32'(overflow), 0);
        cyc(195);
        chk("const_high_novalid", 32'(seen.size()), 0);
        chk("const_high_ovf",     32'(overflow), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
